mem_arbiter: RTL and testbench

- Arbitrates one single-ported RAM between the instruction-fetch requester and the data requester.
- The data side is driven by request_unit's registered dmemREN/dmemWEN; the instruction side is driven by imemREN.
- Sequences each RAM access, latches the returned word and pulses ihit/dhit for exactly one cycle.
- Provides data-first priority with anti-starvation alternation, and a timeout watchdog.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and
// data access. Data side wins under contention unless it won last time, so
// both requesters alternate when both are busy. A watchdog bounds every
// access and raises a sticky error flag if the RAM never answers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | bus idle, choose a requester, register address/write data
// S_IACC   | instruction read in flight, ramREN high
// S_DREAD  | data read in flight, ramREN high
// S_DWRITE | data write in flight, ramWEN high, never aborted
// S_HIT    | one-cycle ihit/dhit pulse for the last grant, then idle
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic [DATA_W-1:0] imemload,
  output logic              ihit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dmemload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  output logic              memerr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IACC,
    S_DREAD,
    S_DWRITE,
    S_HIT
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_data;   // 1: last grant went to the data side
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_dreq;
  logic w_timeout;
  logic w_grant;
  logic w_grant_data;
  logic w_grant_write;
  logic w_cap_i;
  logic w_cap_d;
  logic w_zero_i;
  logic w_zero_d;
  logic w_cnt_inc;
  logic w_err_set;

  assign w_dreq    = dmemREN | dmemWEN;
  assign w_timeout = (r_wait_cnt == CNT_MAX);

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, arbitration and bus/hit outputs.
  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    w_grant_data  = 1'b0;
    w_grant_write = 1'b0;
    w_cap_i       = 1'b0;
    w_cap_d       = 1'b0;
    w_zero_i      = 1'b0;
    w_zero_d      = 1'b0;
    w_cnt_inc     = 1'b0;
    w_err_set     = 1'b0;
    ramREN        = 1'b0;
    ramWEN        = 1'b0;
    ihit          = 1'b0;
    dhit          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dreq || imemREN) begin
          w_grant       = 1'b1;
          // Data wins unless it also won the previous grant and fetch waits.
          w_grant_data  = w_dreq && !(imemREN && r_last_data);
          w_grant_write = w_grant_data && dmemWEN;
          if (w_grant_write) begin
            w_next_state = S_DWRITE;
          end else if (w_grant_data) begin
            w_next_state = S_DREAD;
          end else begin
            w_next_state = S_IACC;
          end
        end
      end
      S_IACC: begin
        ramREN = 1'b1;
        if (!imemREN) begin
          w_next_state = S_IDLE;
        end else if (ramready) begin
          w_cap_i      = 1'b1;
          w_next_state = S_HIT;
        end else if (w_timeout) begin
          w_zero_i     = 1'b1;
          w_err_set    = 1'b1;
          w_next_state = S_HIT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DREAD: begin
        ramREN = 1'b1;
        if (!dmemREN) begin
          w_next_state = S_IDLE;
        end else if (ramready) begin
          w_cap_d      = 1'b1;
          w_next_state = S_HIT;
        end else if (w_timeout) begin
          w_zero_d     = 1'b1;
          w_err_set    = 1'b1;
          w_next_state = S_HIT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DWRITE: begin
        ramWEN = 1'b1;
        if (ramready) begin
          w_next_state = S_HIT;
        end else if (w_timeout) begin
          w_err_set    = 1'b1;
          w_next_state = S_HIT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_HIT: begin
        ihit         = !r_last_data;
        dhit         = r_last_data;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Grant bookkeeping, wait counter, load registers and sticky error.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_last_data <= 1'b0;
      r_wait_cnt  <= '0;
      ramaddr     <= '0;
      ramstore    <= '0;
      imemload    <= '0;
      dmemload    <= '0;
      memerr      <= 1'b0;
    end else begin
      if (w_grant) begin
        r_last_data <= w_grant_data;
        r_wait_cnt  <= '0;
        ramaddr     <= w_grant_data ? dmemaddr : imemaddr;
        if (w_grant_write) begin
          ramstore <= dmemstore;
        end
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if (w_cap_i) begin
        imemload <= ramload;
      end else if (w_zero_i) begin
        imemload <= '0;
      end
      if (w_cap_d) begin
        dmemload <= ramload;
      end else if (w_zero_d) begin
        dmemload <= '0;
      end
      if (w_err_set) begin
        memerr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays the RAM and both requesters, and a
// transaction-level model predicts winner, bus contents, hit and load values.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              CLK;
  logic              nRST;
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic [DATA_W-1:0] imemload;
  logic              ihit;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic [DATA_W-1:0] dmemload;
  logic              dhit;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;
  logic              memerr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_last_data;
  logic [31:0] m_iload;
  logic [31:0] m_dload;
  logic [31:0] m_ramaddr;
  logic [31:0] m_ramstore;
  bit          m_err;
  bit          m_grants[$];   // 1 = data grant, in order

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .memerr(memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got still running exp finished");
    $fatal(1);
  end

  task automatic model_reset();
    m_last_data = 1'b0;
    m_iload     = '0;
    m_dload     = '0;
    m_ramaddr   = '0;
    m_ramstore  = '0;
    m_err       = 1'b0;
  endtask

  task automatic drive_idle_inputs();
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    imemaddr  = '0;
    dmemaddr  = '0;
    dmemstore = '0;
    ramload   = '0;
    ramready  = 1'b0;
  endtask

  // Called at a negedge inside an IDLE cycle; returns at the negedge of the
  // next IDLE cycle. ready_at / drop_at index access cycles (-1 = never).
  task automatic run_txn(input bit ri, input bit rdr, input bit rdw,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] ds, input int ready_at,
                         input int drop_at, input bit use_rl,
                         input logic [31:0] rl);
    bit win_data, win_write, done, aborted;
    n_vec++;
    if ({ramREN, ramWEN, ihit, dhit} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_bus: got %b exp 0000", {ramREN, ramWEN, ihit, dhit});
    end
    n_vec++;
    if ({imemload, dmemload, memerr} !== {m_iload, m_dload, m_err}) begin
      n_err++;
      $display("FAIL idle_hold: got %h %h %b exp %h %h %b",
               imemload, dmemload, memerr, m_iload, m_dload, m_err);
    end
    imemREN   = ri;
    dmemREN   = rdr;
    dmemWEN   = rdw;
    imemaddr  = ia;
    dmemaddr  = da;
    dmemstore = ds;
    ramready  = 1'b0;
    if (!ri && !rdr && !rdw) begin
      @(negedge CLK);
      return;
    end
    win_data  = (rdr || rdw) && !(ri && m_last_data);
    win_write = win_data && rdw;
    m_last_data = win_data;
    m_grants.push_back(win_data);
    m_ramaddr = win_data ? da : ia;
    if (win_write) m_ramstore = ds;
    done    = 1'b0;
    aborted = 1'b0;
    for (int c = 0; !done; c++) begin
      @(negedge CLK);
      n_vec++;
      if ({ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, memerr} !==
          {!win_write, win_write, m_ramaddr, m_ramstore, 2'b00, m_err}) begin
        n_err++;
        $display("FAIL access_bus c=%0d: got ren=%b wen=%b a=%h s=%h ih=%b dh=%b e=%b exp ren=%b wen=%b a=%h s=%h e=%b",
                 c, ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, memerr,
                 !win_write, win_write, m_ramaddr, m_ramstore, m_err);
      end
      ramload  = use_rl ? rl : $urandom;
      ramready = (c == ready_at);
      if (c == drop_at) begin
        if (!win_data) imemREN = 1'b0;
        else if (win_write) dmemWEN = 1'b0;
        else dmemREN = 1'b0;
      end
      if (c == drop_at && !win_write) begin
        aborted = 1'b1;
        done    = 1'b1;
      end else if (ramready) begin
        if (!win_write) begin
          if (win_data) m_dload = ramload;
          else m_iload = ramload;
        end
        done = 1'b1;
      end else if (c == TIMEOUT - 1) begin
        m_err = 1'b1;
        if (!win_write) begin
          if (win_data) m_dload = '0;
          else m_iload = '0;
        end
        done = 1'b1;
      end
    end
    @(negedge CLK);
    ramready = 1'b0;
    if (aborted) begin
      n_vec++;
      if ({ramREN, ramWEN, ihit, dhit, imemload, dmemload} !==
          {4'b0000, m_iload, m_dload}) begin
        n_err++;
        $display("FAIL abort_idle: got ren=%b wen=%b ih=%b dh=%b il=%h dl=%h exp 0 0 0 0 il=%h dl=%h",
                 ramREN, ramWEN, ihit, dhit, imemload, dmemload, m_iload, m_dload);
      end
    end else begin
      n_vec++;
      if ({ihit, dhit, ramREN, ramWEN, imemload, dmemload, memerr} !==
          {!win_data, win_data, 2'b00, m_iload, m_dload, m_err}) begin
        n_err++;
        $display("FAIL hit: got ih=%b dh=%b ren=%b wen=%b il=%h dl=%h e=%b exp ih=%b dh=%b 0 0 il=%h dl=%h e=%b",
                 ihit, dhit, ramREN, ramWEN, imemload, dmemload, memerr,
                 !win_data, win_data, m_iload, m_dload, m_err);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    drive_idle_inputs();
    repeat (2) @(negedge CLK);
    n_vec++;
    if ({ihit, dhit, ramREN, ramWEN, imemload, dmemload, ramaddr, ramstore, memerr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ih=%b dh=%b ren=%b wen=%b il=%h dl=%h a=%h s=%h e=%b exp all 0",
               ihit, dhit, ramREN, ramWEN, imemload, dmemload, ramaddr, ramstore, memerr);
    end
    nRST = 1'b1;
    model_reset();
    m_grants.delete();
    @(negedge CLK);
  endtask

  task automatic test_instr_read();
    run_txn(1, 0, 0, 32'h40, 32'h0, 32'h0, 1, -1, 1, 32'h8C220004);
    n_vec++;
    if (imemload !== 32'h8C220004) begin
      n_err++;
      $display("FAIL instr_read_load: got %h exp 8c220004", imemload);
    end
  endtask

  task automatic test_alternation();
    test_reset();
    for (int k = 0; k < 4; k++)
      run_txn(1, 1, 0, $urandom, $urandom, $urandom, 0, -1, 0, '0);
    n_vec++;
    if ({m_grants[0], m_grants[1], m_grants[2], m_grants[3]} !== 4'b1010 ||
        {imemload, dmemload} !== {m_iload, m_dload}) begin
      n_err++;
      $display("FAIL alternation: got il=%h dl=%h exp il=%h dl=%h (order DATA,INSTR,DATA,INSTR)",
               imemload, dmemload, m_iload, m_dload);
    end
  endtask

  task automatic test_write();
    run_txn(0, 1, 0, 32'h0, 32'h200, 32'h0, 0, -1, 1, 32'h12345678);
    run_txn(0, 0, 1, 32'h0, 32'h100, 32'hDEADBEEF, 3, 0, 0, '0);
    n_vec++;
    if ({ramstore, dmemload} !== {32'hDEADBEEF, 32'h12345678}) begin
      n_err++;
      $display("FAIL write_store: got s=%h dl=%h exp s=deadbeef dl=12345678",
               ramstore, dmemload);
    end
  endtask

  task automatic test_read_abort();
    run_txn(0, 1, 0, 32'h0, 32'h300, 32'h0, 0, -1, 1, 32'hA5A5_0001);
    run_txn(0, 1, 0, 32'h0, 32'h304, 32'h0, 3, 1, 1, 32'hBAD0_0001);
    run_txn(1, 0, 0, 32'h308, 32'h0, 32'h0, 0, 0, 1, 32'hBAD0_0002);
    run_txn(0, 1, 0, 32'h0, 32'h30C, 32'h0, 2, 2, 1, 32'hBAD0_0003);
  endtask

  task automatic test_timeout();
    run_txn(1, 0, 0, 32'h500, 32'h0, 32'h0, 2, -1, 1, 32'h1111_2222);
    run_txn(1, 0, 0, 32'h504, 32'h0, 32'h0, -1, -1, 0, '0);
    n_vec++;
    if ({memerr, imemload} !== {1'b1, 32'h0}) begin
      n_err++;
      $display("FAIL timeout_err: got e=%b il=%h exp e=1 il=00000000", memerr, imemload);
    end
    run_txn(0, 1, 0, 32'h0, 32'h508, 32'h0, 1, -1, 0, '0);
    run_txn(0, 0, 1, 32'h0, 32'h50C, $urandom, -1, -1, 0, '0);
    run_txn(1, 0, 0, 32'h510, 32'h0, 32'h0, 0, -1, 0, '0);
  endtask

  task automatic test_reset_mid();
    run_txn(0, 1, 0, 32'h0, 32'h600, 32'h0, 0, -1, 1, 32'h7777_0000);
    dmemREN  = 1'b1;
    dmemaddr = 32'h604;
    @(negedge CLK);
    ramready = 1'b1;
    ramload  = 32'hCAFE_F00D;
    nRST     = 1'b0;
    #1;
    n_vec++;
    if ({ramREN, dhit, ramaddr, dmemload} !== {2'b10, 32'h604, 32'h7777_0000}) begin
      n_err++;
      $display("FAIL reset_sync: got ren=%b dh=%b a=%h dl=%h exp ren=1 dh=0 a=00000604 dl=77770000",
               ramREN, dhit, ramaddr, dmemload);
    end
    @(negedge CLK);
    n_vec++;
    if ({ihit, dhit, ramREN, ramWEN, imemload, dmemload, ramaddr, ramstore, memerr} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got ih=%b dh=%b ren=%b wen=%b il=%h dl=%h a=%h s=%h e=%b exp all 0",
               ihit, dhit, ramREN, ramWEN, imemload, dmemload, ramaddr, ramstore, memerr);
    end
    nRST = 1'b1;
    drive_idle_inputs();
    model_reset();
    @(negedge CLK);
    run_txn(1, 1, 0, 32'h700, 32'h704, 32'h0, 1, -1, 0, '0);
  endtask

  task automatic test_random();
    int rdy, drp;
    for (int k = 0; k < 80; k++) begin
      rdy = $urandom_range(0, 4);
      drp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, rdy) : -1;
      run_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom, $urandom, $urandom,
              rdy, drp, 0, '0);
    end
  endtask

  initial begin
    drive_idle_inputs();
    nRST = 1'b0;
    model_reset();
    @(negedge CLK);
    test_reset();
    test_instr_read();
    test_alternation();
    test_write();
    test_read_abort();
    test_timeout();
    test_reset_mid();
    test_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
